accum_sequencer: RTL and testbench
==================================

Name: accum_sequencer

Overview:
- Run-level controller for the power-spectrum accumulation buffer.
- Arms on a host start command and gates N laser-pulse spectrum frames into the buffer.
  - Drives the first-pulse flag and the accumulate/readout mode select.
  - Switches the buffer to readout after the last frame, counts readout beats, then signals done.
- Sits between the trigger/FFT front end and the accumulation buffer; reports status to the host register bank.

Parameters:
- BINS_PER_FRAME, 8192, spectrum beats per pulse frame (512 bins x 16 range gates).
- BIN_CNT_W, 14, width of the beat counters; must hold BINS_PER_FRAME.
- PULSE_CNT_W, 16, width of the pulse counters.
- DRAIN_CYC, 6, cycles buffer_en stays high after the last valid_in beat, covering buffer write latency.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  single-cycle run request; accepted only in IDLE
- abort  in  1  single-cycle run cancel; any state
- num_pulses  in  PULSE_CNT_W  pulses to accumulate; latched on accepted start
- trigger_start  in  1  laser-pulse trigger, single-cycle
- valid_in  in  1  spectrum beat valid (frame = BINS_PER_FRAME consecutive-or-gapped beats)
- valid_out  in  1  readout beat valid returned from buffer
- buffer_en  out  1  1 = accumulate mode, 0 = readout mode
- is_first_pls  out  1  high while the frame being written is the first of the run
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at run completion
- pulse_count  out  PULSE_CNT_W  frames completed in the current/last run
- err_sticky  out  2  bit0 orphan beat, bit1 trigger during frame; cleared on accepted start

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - All outputs 0; state IDLE; counters 0; latched N = 1.
- IDLE:
  - start → latch N (num_pulses==0 treated as 1), clear pulse_count, beat counter and err_sticky → WAIT_TRIG.
  - start outside IDLE is ignored.
- WAIT_TRIG:
  - buffer_en=1.
  - trigger_start → ACCUM next cycle.
  - valid_in here is not counted; sets err_sticky[0].
- ACCUM:
  - buffer_en=1; each valid_in cycle increments the beat counter.
  - On the beat making count == BINS_PER_FRAME: clear the beat counter and increment pulse_count in the same cycle.
    - If new pulse_count == N → DRAIN.
    - Otherwise → WAIT_TRIG.
  - trigger_start in ACCUM: sets err_sticky[1], no state change.
  - trigger_start coincident with the final beat is also flagged; it does not pre-arm the next frame.
- is_first_pls:
  - = 1 in WAIT_TRIG and ACCUM while pulse_count==0.
  - Registered; falls the cycle after the first frame's final beat.
  - 0 in all other states.
- DRAIN:
  - buffer_en=1 for exactly DRAIN_CYC cycles, counted from DRAIN entry → READOUT.
  - valid_in in DRAIN sets err_sticky[0].
- READOUT:
  - buffer_en=0; count valid_out beats.
  - On the beat reaching BINS_PER_FRAME → DONE.
  - No timeout; abort is the only exit before completion.
- DONE:
  - done=1 for one cycle → IDLE.
  - pulse_count holds its final value until the next accepted start.
- abort:
  - From any non-IDLE state → IDLE next cycle; buffer_en=0, is_first_pls=0; no done pulse.
  - pulse_count retains the partial value.
  - abort together with start in IDLE: abort wins, run not started.
- Counters saturate: they never wrap.
  - pulse_count stops at N.
  - Beat counters reset on frame completion and on state exit.
- buffer_en and is_first_pls are registered outputs: state transition at edge k gives output change at edge k+1 at the latest.

Test Plan:
- Basic run: BINS_PER_FRAME=16, N=3, three trigger+16-beat frames, 16 valid_out beats → is_first_pls high only during frame 1; pulse_count 1,2,3; buffer_en falls 6 cycles after last beat; done one cycle after 16th readout beat; err_sticky=0.
- N=0 edge: start with num_pulses=0 → behaves as N=1; done after one frame plus 16 readout beats; pulse_count=1.
- Orphan and early trigger: 4 valid_in beats before any trigger, then trigger_start at beat 8 of frame 1 → err_sticky=2'b11; frame still completes at beat 16; pulse_count=1.
- Gapped beats: 16 beats interleaved with idle cycles of random length → frame completes exactly on 16th valid beat; no early transition.
- Abort mid-ACCUM: N=4, abort during frame 2 beat 5 → IDLE next cycle, buffer_en=0, busy=0, no done, pulse_count=1; new start clears pulse_count and err_sticky.
- Reset mid-READOUT: assert rst asynchronously between clock edges → all outputs 0 immediately; post-reset start runs normally.

Source files
------------

// File: rtl/accum_sequencer.sv
// accum_sequencer
// Run-level controller for the power-spectrum accumulation buffer.
// A host start arms a run of N laser-pulse frames. Each frame begins on a
// trigger and ends after BINS_PER_FRAME valid_in beats. After the last frame
// the buffer gets DRAIN_CYC more accumulate cycles so in-flight writes can
// land. It is then switched to readout until BINS_PER_FRAME valid_out beats
// have returned, and done pulses for one cycle.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           single-cycle run request (honoured only in IDLE)
//   abort           single-cycle run cancel (any state, beats start)
//   num_pulses      frames per run, latched on accepted start (0 -> 1)
//   trigger_start   laser-pulse trigger
//   valid_in        spectrum beat valid from the FFT front end
//   valid_out       readout beat valid from the buffer
//   buffer_en       1 = accumulate mode, 0 = readout mode (registered)
//   is_first_pls    first frame of the run is being written (registered)
//   busy            any state other than IDLE
//   done            one-cycle completion pulse
//   pulse_count     frames completed in the current/last run
//   err_sticky      [0] orphan beat, [1] trigger during frame
module accum_sequencer #(
  parameter int BINS_PER_FRAME = 8192,
  parameter int BIN_CNT_W      = 14,
  parameter int PULSE_CNT_W    = 16,
  parameter int DRAIN_CYC      = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PULSE_CNT_W-1:0] num_pulses,
  input  logic                   trigger_start,
  input  logic                   valid_in,
  input  logic                   valid_out,
  output logic                   buffer_en,
  output logic                   is_first_pls,
  output logic                   busy,
  output logic                   done,
  output logic [PULSE_CNT_W-1:0] pulse_count,
  output logic [1:0]             err_sticky
);

  localparam logic [BIN_CNT_W-1:0] LAST_BEAT = BIN_CNT_W'(BINS_PER_FRAME - 1);
  localparam int                   DRN_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRN_W-1:0]     LAST_DRN  = DRN_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TRIG,
    S_ACCUM,
    S_DRAIN,
    S_READOUT,
    S_DONE
  } state_t;

  state_t                 state;
  logic [PULSE_CNT_W-1:0] n_lat;      // pulses requested for this run
  logic [BIN_CNT_W-1:0]   beat_cnt;   // valid_in beats in the current frame
  logic [BIN_CNT_W-1:0]   rd_cnt;     // valid_out beats during readout
  logic [DRN_W-1:0]       drn_cnt;    // cycles spent in DRAIN
  logic [PULSE_CNT_W-1:0] pulse_inc;

  assign pulse_inc = pulse_count + PULSE_CNT_W'(1);

  // Outputs are assigned alongside the state they belong to, so they track
  // the state register without any combinational decode on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      n_lat        <= PULSE_CNT_W'(1);
      beat_cnt     <= '0;
      rd_cnt       <= '0;
      drn_cnt      <= '0;
      buffer_en    <= 1'b0;
      is_first_pls <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pulse_count  <= '0;
      err_sticky   <= '0;
    end else begin
      done <= 1'b0;

      if (abort && state != S_IDLE) begin
        // pulse_count and err_sticky are kept so the host can inspect the
        // partial run.
        state        <= S_IDLE;
        beat_cnt     <= '0;
        rd_cnt       <= '0;
        drn_cnt      <= '0;
        buffer_en    <= 1'b0;
        is_first_pls <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // abort in the same cycle cancels the request.
            if (start && !abort) begin
              state        <= S_WAIT_TRIG;
              n_lat        <= (num_pulses == '0) ? PULSE_CNT_W'(1) : num_pulses;
              pulse_count  <= '0;
              beat_cnt     <= '0;
              err_sticky   <= '0;
              buffer_en    <= 1'b1;
              is_first_pls <= 1'b1;
              busy         <= 1'b1;
            end
          end

          S_WAIT_TRIG: begin
            buffer_en    <= 1'b1;
            is_first_pls <= (pulse_count == '0);
            // A beat with no frame open is not counted, only flagged.
            if (valid_in)
              err_sticky[0] <= 1'b1;
            if (trigger_start)
              state <= S_ACCUM;
          end

          S_ACCUM: begin
            buffer_en <= 1'b1;
            // Flagged even when it coincides with the final beat; such a
            // trigger does not open the next frame.
            if (trigger_start)
              err_sticky[1] <= 1'b1;
            if (valid_in) begin
              if (beat_cnt == LAST_BEAT) begin
                beat_cnt     <= '0;
                is_first_pls <= 1'b0;
                if (pulse_count != n_lat)
                  pulse_count <= pulse_inc;
                if (pulse_inc == n_lat) begin
                  state   <= S_DRAIN;
                  drn_cnt <= '0;
                end else begin
                  state <= S_WAIT_TRIG;
                end
              end else begin
                beat_cnt <= beat_cnt + BIN_CNT_W'(1);
              end
            end
          end

          S_DRAIN: begin
            // buffer_en has been high since the entry edge; it drops on the
            // edge that ends the DRAIN_CYC-th DRAIN cycle.
            if (valid_in)
              err_sticky[0] <= 1'b1;
            if (drn_cnt == LAST_DRN) begin
              state     <= S_READOUT;
              drn_cnt   <= '0;
              rd_cnt    <= '0;
              buffer_en <= 1'b0;
            end else begin
              drn_cnt   <= drn_cnt + DRN_W'(1);
              buffer_en <= 1'b1;
            end
          end

          S_READOUT: begin
            buffer_en <= 1'b0;
            if (valid_out) begin
              if (rd_cnt == LAST_BEAT) begin
                state  <= S_DONE;
                rd_cnt <= '0;
                done   <= 1'b1;
              end else begin
                rd_cnt <= rd_cnt + BIN_CNT_W'(1);
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state        <= S_IDLE;
            buffer_en    <= 1'b0;
            is_first_pls <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
module tb_accum_sequencer;

  localparam int BINS  = 16;
  localparam int PCW   = 16;
  localparam int DRAIN = 6;

  logic           clk, rst;
  logic           start, abort, trigger_start, valid_in, valid_out;
  logic [PCW-1:0] num_pulses;
  logic           buffer_en, is_first_pls, busy, done;
  logic [PCW-1:0] pulse_count;
  logic [1:0]     err_sticky;

  accum_sequencer #(
    .BINS_PER_FRAME(BINS), .BIN_CNT_W(14), .PULSE_CNT_W(PCW), .DRAIN_CYC(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pulses(num_pulses),
    .trigger_start(trigger_start), .valid_in(valid_in), .valid_out(valid_out),
    .buffer_en(buffer_en), .is_first_pls(is_first_pls), .busy(busy), .done(done),
    .pulse_count(pulse_count), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [1:0]     err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   dones_seen = 0, dones_exp = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the next queued result.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      dones_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        e = sb.pop_front();
        check("done_pulse_count", 32'(pulse_count), 32'(e.pc));
        check("done_err_sticky", 32'(err_sticky), 32'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [PCW-1:0] n);
    num_pulses = n;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic trig();
    trigger_start = 1'b1;
    cyc();
    trigger_start = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      cyc();
    end
    valid_in = 1'b0;
  endtask

  // Called right after the final beat of the last frame.
  task automatic tail(input logic [PCW-1:0] pc, input logic [1:0] err);
    repeat (DRAIN - 1) cyc();
    check("drain_buffer_en_hi", 32'(buffer_en), 1);
    cyc();
    check("drain_buffer_en_lo", 32'(buffer_en), 0);
    sb.push_back('{pc: pc, err: err});
    dones_exp++;
    for (int i = 0; i < BINS - 1; i++) begin
      valid_out = 1'b1;
      cyc();
    end
    check("readout_no_early_done", 32'(done), 0);
    cyc();
    valid_out = 1'b0;
    check("readout_done", 32'(done), 1);
    cyc();
    check("done_single_cycle", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("pulse_count_held", 32'(pulse_count), 32'(pc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 0; abort = 0; trigger_start = 0; valid_in = 0; valid_out = 0;
    num_pulses = '0;
    #12;
    check("rst_buffer_en", 32'(buffer_en), 0);
    check("rst_is_first", 32'(is_first_pls), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pulse_count", 32'(pulse_count), 0);
    check("rst_err", 32'(err_sticky), 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc();

    // Basic run, N=3
    start_run(3);
    check("start_busy", 32'(busy), 1);
    check("start_buffer_en", 32'(buffer_en), 1);
    check("start_is_first", 32'(is_first_pls), 1);
    trig();
    beats(BINS - 1);
    check("f1_is_first_mid", 32'(is_first_pls), 1);
    check("f1_pc_mid", 32'(pulse_count), 0);
    beats(1);
    check("f1_pc", 32'(pulse_count), 1);
    check("f1_is_first_fall", 32'(is_first_pls), 0);
    check("f1_buffer_en", 32'(buffer_en), 1);
    trig();
    beats(4);
    check("f2_is_first", 32'(is_first_pls), 0);
    beats(BINS - 4);
    check("f2_pc", 32'(pulse_count), 2);
    trig();
    beats(BINS);
    check("f3_pc", 32'(pulse_count), 3);
    tail(3, 2'b00);

    // N=0 behaves as N=1
    start_run(0);
    trig();
    beats(BINS);
    check("n0_pc", 32'(pulse_count), 1);
    tail(1, 2'b00);

    // Orphan beats and early trigger
    start_run(1);
    beats(4);
    check("orphan_err", 32'(err_sticky), 1);
    check("orphan_is_first", 32'(is_first_pls), 1);
    trig();
    beats(7);
    trigger_start = 1'b1;
    beats(1);
    trigger_start = 1'b0;
    check("early_trig_err", 32'(err_sticky), 3);
    beats(BINS - 9);
    check("early_trig_pc_mid", 32'(pulse_count), 0);
    beats(1);
    check("early_trig_pc", 32'(pulse_count), 1);
    tail(1, 2'b11);

    // Gapped beats
    start_run(1);
    trig();
    for (int i = 0; i < BINS; i++) begin
      valid_in = 1'b1;
      cyc();
      valid_in = 1'b0;
      if (i == BINS - 2) begin
        check("gap_pc_mid", 32'(pulse_count), 0);
        check("gap_is_first_mid", 32'(is_first_pls), 1);
      end
      if (i < BINS - 1)
        repeat ($urandom_range(0, 3)) cyc();
    end
    check("gap_pc", 32'(pulse_count), 1);
    tail(1, 2'b00);

    // Abort mid-ACCUM, N=4
    start_run(4);
    beats(1);  // orphan so err_sticky has something to retain/clear
    trig();
    beats(BINS);
    trig();
    beats(4);
    valid_in = 1'b1;
    abort = 1'b1;
    cyc();
    valid_in = 1'b0;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_buffer_en", 32'(buffer_en), 0);
    check("abort_is_first", 32'(is_first_pls), 0);
    check("abort_pc", 32'(pulse_count), 1);
    check("abort_err_kept", 32'(err_sticky), 1);
    repeat (4) cyc();
    // abort and start together in IDLE: run must not start
    num_pulses = 2;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    check("abort_wins_busy", 32'(busy), 0);
    start_run(1);
    check("restart_pc_clear", 32'(pulse_count), 0);
    check("restart_err_clear", 32'(err_sticky), 0);

    // Reset mid-READOUT
    trig();
    beats(BINS);
    repeat (DRAIN) cyc();
    valid_out = 1'b1;
    repeat (8) cyc();
    valid_out = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_pc", 32'(pulse_count), 0);
    check("arst_buffer_en", 32'(buffer_en), 0);
    cyc();
    rst = 1'b0;
    cyc();
    start_run(1);
    trig();
    beats(BINS);
    check("post_rst_pc", 32'(pulse_count), 1);
    tail(1, 2'b00);

    repeat (3) cyc();
    check("done_count", 32'(dones_seen), 32'(dones_exp));
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
